// File: rtl/mem_bus_if_if.sv
// External data-bus bundle between the MEM-stage port (master) and the memory (slave).
// Request/acknowledge with wait states; read data is valid in the ack cycle.
interface mem_bus_if_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   localparam int SEL_W = DATA_W / 8;

   logic              bus_req_o;
   logic              bus_we_o;
   logic [ADDR_W-1:0] bus_addr_o;
   logic [SEL_W-1:0]  bus_sel_o;
   logic [DATA_W-1:0] bus_wdata_o;
   logic              bus_ack_i;
   logic [DATA_W-1:0] bus_rdata_i;

   modport master (
      output bus_req_o,
      output bus_we_o,
      output bus_addr_o,
      output bus_sel_o,
      output bus_wdata_o,
      input  bus_ack_i,
      input  bus_rdata_i
   );

   modport slave (
      input  bus_req_o,
      input  bus_we_o,
      input  bus_addr_o,
      input  bus_sel_o,
      input  bus_wdata_o,
      output bus_ack_i,
      output bus_rdata_i
   );
endinterface

// File: rtl/mem_bus_if.sv
// MEM-stage data-memory port: turns a single-cycle core access into a req/ack bus
// transaction and stalls the pipeline until it completes. MEM_BUS_TIMEOUT_EN adds a wait-cycle abort.
module mem_bus_if #(
   parameter  int DATA_W  = 32,
   parameter  int ADDR_W  = 32,
   parameter  int TIMEOUT = 255,
   localparam int SEL_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [SEL_W-1:0]  sel_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              stallreq_o,
   output logic              err_o,
   mem_bus_if_if.master      bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              drop_q, drop_d;
   logic              stall_s;
   logic              start_s;
   logic              ack_s;
   logic              drop_now_s;

`ifdef MEM_BUS_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
   logic [15:0] cnt_q, cnt_d;
   logic        err_q, err_d;
`endif

   // Out-of-range TIMEOUT values leave no legal configuration; nothing is generated here.
   if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_timeout_range_bad
   end

   assign start_s    = req_i & ~flush_i;
   assign ack_s      = bus.bus_ack_i & bus_req_q;
   assign drop_now_s = drop_q | flush_i;

   // Next-state, bus latching and stall request.
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_sel_d   = bus_sel_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = rdata_q;
      drop_d      = drop_q;
      stall_s     = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            stall_s = start_s;
            if (start_s) begin
               bus_req_d   = 1'b1;
               bus_we_d    = we_i;
               bus_addr_d  = addr_i;
               bus_sel_d   = sel_i;
               bus_wdata_d = wdata_i;
               drop_d      = 1'b0;
               state_d     = ST_BUSY;
`ifdef MEM_BUS_TIMEOUT_EN
               cnt_d       = 16'd0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            stall_s = 1'b1;
            if (ack_s) begin
               bus_req_d = 1'b0;
               drop_d    = 1'b0;
               if (drop_now_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DONE;
                  if (!bus_we_q) begin
                     rdata_d = bus.bus_rdata_i;
                  end else begin
                     rdata_d = rdata_q;
                  end
               end
            end else begin
               // A flush only marks the result as unwanted; the bus access still runs to ack.
               drop_d = drop_now_s;
`ifdef MEM_BUS_TIMEOUT_EN
               if (cnt_q == TO_LAST) begin
                  bus_req_d = 1'b0;
                  drop_d    = 1'b0;
                  err_d     = 1'b1;
                  if (drop_now_s) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_DONE;
                     rdata_d = {DATA_W{1'b1}};
                  end
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
`endif
            end
         end
         ST_DONE: begin
            // req_i still high here belongs to the access just completed.
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            bus_req_d = 1'b0;
            drop_d    = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= {ADDR_W{1'b0}};
         bus_sel_q   <= {SEL_W{1'b0}};
         bus_wdata_q <= {DATA_W{1'b0}};
         rdata_q     <= {DATA_W{1'b0}};
         drop_q      <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
         cnt_q       <= 16'd0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_sel_q   <= bus_sel_d;
         bus_wdata_q <= bus_wdata_d;
         rdata_q     <= rdata_d;
         drop_q      <= drop_d;
`ifdef MEM_BUS_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign stallreq_o      = stall_s & ~rst;
   assign rdata_o         = rdata_q;
   assign bus.bus_req_o   = bus_req_q;
   assign bus.bus_we_o    = bus_we_q;
   assign bus.bus_addr_o  = bus_addr_q;
   assign bus.bus_sel_o   = bus_sel_q;
   assign bus.bus_wdata_o = bus_wdata_q;

`ifdef MEM_BUS_TIMEOUT_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
